vdiv_lane_sched: RTL
====================

Name: vdiv_lane_sched

Overview:
Sequencer that time-shares one iterative FP divider across the lanes of a vector divide operation. It accepts a full vector of operand pairs with a lane mask and issues unmasked lanes to the divider one at a time, in ascending lane order. It collects each quotient into a result buffer and presents the assembled vector on a valid/ready output. It sits between the vector FU issue stage and the scalar FP divide unit.

Parameters:
NUM_LANES, 4, vector lanes per operation (≥1).
EXP_WIDTH, 5, FP exponent width.
MANT_WIDTH, 10, FP mantissa width; element width W = 1+EXP_WIDTH+MANT_WIDTH (derived localparam).

Ports:
CLK  in  1  clock
nRST  in  1  reset
in_valid  in  1  vector request valid
in_ready  out  1  scheduler can accept a vector
in_a  in  NUM_LANES*W  dividends; lane i at [i*W +: W]
in_b  in  NUM_LANES*W  divisors; same packing
in_mask  in  NUM_LANES  1 = lane active
out_valid  out  1  result vector valid
out_ready  in  1  consumer accepts result
out_result  out  NUM_LANES*W  quotients; masked lanes = 0
div_req_valid  out  1  operand pair offered to divider
div_req_ready  in  1  divider accepts operands
div_op1  out  W  dividend of current lane
div_op2  out  W  divisor of current lane
div_rsp_valid  in  1  divider result valid
div_rsp_ready  out  1  scheduler accepts result
div_result  in  W  divider quotient
busy  out  1  state != IDLE

Behaviour:
- Reset nRST, asynchronous, active-low; clock CLK. On reset:
  - state = IDLE, lane index = 0, operand/mask/result buffers = 0.
  - out_valid = 0, div_req_valid = 0, div_rsp_ready = 0, busy = 0, in_ready = 1.
- Reset mid-operation aborts the vector with no output. The divider shares nRST.
- States: IDLE, ISSUE, WAIT, DONE. Outputs are decoded from registered state:
  - in_ready = (IDLE)
  - div_req_valid = (ISSUE)
  - div_rsp_ready = (WAIT)
  - out_valid = (DONE)
- IDLE: when in_valid && in_ready, latch in_a, in_b and in_mask, and clear the result buffer.
  - Lane index = lowest set bit of in_mask; next state = ISSUE.
  - If in_mask == 0, next state = DONE with an all-zero result.
- ISSUE:
  - div_op1/div_op2 = latched lane[idx] operands, held stable while div_req_valid && !div_req_ready.
  - On div_req_valid && div_req_ready, go to WAIT.
  - div_rsp_valid is ignored in ISSUE; div_rsp_ready = 0.
- WAIT: on div_rsp_valid, write div_result into result lane idx.
  - Next lane = lowest set mask bit above idx (combinational priority search, same cycle).
  - If a next lane exists, go to ISSUE with idx = that lane; otherwise go to DONE.
- DONE:
  - out_result is the registered buffer, stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle accept of a new vector.
- Masked lanes are never issued to the divider; their result field is 0.
- Latency per active lane = 1 ISSUE cycle (more if div_req_ready is low) + divider response latency + 0 turnaround cycles.
  - Total from accept to out_valid = sum of per-lane latencies. An all-masked vector takes 1 cycle.
- The scheduler does not interpret FP values. Special cases (NaN/Inf/zero/subnormal flush) come from the divider unchanged.
- Exactly one divider transaction is outstanding at any time.

Test Plan:
- Full mask, fp16 (mock divider with 13-cycle fixed latency), lanes a/b:
  - a = {3C00, 4600, 3C00, 0000}, b = {4000, 4200, 0000, 0000}
  - Required: out_result = {3800, 4000, 7C00, 7E00}; exactly 4 div requests, in lane order 0..3.
- Mask = 4'b1010, same operands:
  - Only lanes 1 and 3 issued.
  - Required: out_result = {0000, 4000, 0000, 7E00}.
- Mask = 0:
  - Required: out_valid asserted the cycle after accept, out_result = 0, no div_req_valid.
- Backpressure on both sides:
  - div_req_ready low for 3 cycles: div_op1/op2 stay stable.
  - out_ready low for 5 cycles: out_result stays stable, in_ready stays 0.
  - Asserting in_valid during this window is not accepted.
- Back-to-back vectors: second in_valid held high.
  - Required: accepted exactly one cycle after the first out_valid && out_ready.
  - Results are not mixed between vectors.
- nRST pulsed in WAIT (mid lane 2):
  - Required: outputs return to reset values asynchronously.
  - The next vector completes correctly with no stale lane data.

Source files
------------

// File: rtl/vdiv_lane_sched.sv
// Vector divide lane sequencer: issues the unmasked lanes of one vector to a
// single shared iterative divider in ascending order and assembles the quotients.
module vdiv_lane_sched #(
  parameter  int NUM_LANES  = 4,
  parameter  int EXP_WIDTH  = 5,
  parameter  int MANT_WIDTH = 10,
  localparam int W          = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_LANES*W-1:0] in_a,
  input  logic [NUM_LANES*W-1:0] in_b,
  input  logic [NUM_LANES-1:0]   in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_LANES*W-1:0] out_result,
  output logic                   div_req_valid,
  input  logic                   div_req_ready,
  output logic [W-1:0]           div_op1,
  output logic [W-1:0]           div_op2,
  input  logic                   div_rsp_valid,
  output logic                   div_rsp_ready,
  input  logic [W-1:0]           div_result,
  output logic                   busy
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [IDX_W-1:0]       idx_r;
  logic [NUM_LANES*W-1:0] a_r;
  logic [NUM_LANES*W-1:0] b_r;
  logic [NUM_LANES-1:0]   mask_r;
  logic [IDX_W-1:0]       first_idx_s;
  logic [IDX_W-1:0]       next_idx_s;
  logic                   next_found_s;

  // Lowest active lane of an incoming vector.
  always_comb begin
    first_idx_s = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (in_mask[i]) begin
        first_idx_s = IDX_W'(i);
      end else begin
        first_idx_s = first_idx_s;
      end
    end
  end

  // Lowest latched active lane strictly above the current one.
  always_comb begin
    next_found_s = 1'b0;
    next_idx_s   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_r[i] && (i > int'(idx_r))) begin
        next_found_s = 1'b1;
        next_idx_s   = IDX_W'(i);
      end else begin
        next_found_s = next_found_s;
        next_idx_s   = next_idx_s;
      end
    end
  end

  // Next-state decision for the sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nx_s = (in_mask == '0) ? DONE : ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        if (div_req_ready) begin
          state_nx_s = WAIT;
        end else begin
          state_nx_s = ISSUE;
        end
      end
      WAIT: begin
        if (div_rsp_valid) begin
          state_nx_s = next_found_s ? ISSUE : DONE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, buffers and registered handshake outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      a_r           <= '0;
      b_r           <= '0;
      mask_r        <= '0;
      out_result    <= '0;
      div_op1       <= '0;
      div_op2       <= '0;
      in_ready      <= 1'b1;
      div_req_valid <= 1'b0;
      div_rsp_ready <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      in_ready      <= (state_nx_s == IDLE);
      div_req_valid <= (state_nx_s == ISSUE);
      div_rsp_ready <= (state_nx_s == WAIT);
      out_valid     <= (state_nx_s == DONE);
      busy          <= (state_nx_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r        <= in_a;
            b_r        <= in_b;
            mask_r     <= in_mask;
            out_result <= '0;
            idx_r      <= first_idx_s;
            div_op1    <= in_a[first_idx_s*W +: W];
            div_op2    <= in_b[first_idx_s*W +: W];
          end
        end
        WAIT: begin
          if (div_rsp_valid) begin
            out_result[idx_r*W +: W] <= div_result;
            // Operands for the following lane are staged together with the jump back to ISSUE.
            if (next_found_s) begin
              idx_r   <= next_idx_s;
              div_op1 <= a_r[next_idx_s*W +: W];
              div_op2 <= b_r[next_idx_s*W +: W];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
